seq_divider32: RTL and testbench

//  Iterative restoring integer divider: the inverse of the chip's adder/multiplier datapath.

---
 rtl/seq_divider32.sv | 161 ++++++++++++++++
 tb/tb_seq_divider32.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned WX = WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic             busy_next;
    logic             done_next;
    logic             start_acc;
    logic             load_out;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] a_orig;
    logic             a_neg;
    logic             b_neg;
    logic             sgn;
    logic             bzero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WX-1:0]    shifted;
    logic [WX-1:0]    trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // State register plus registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            Busy  <= busy_next;
            Done  <= done_next;
        end
    end

    // Next-state and control decode; Start is only honoured in IDLE or DONE
    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        load_out   = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_CALC;
                    start_acc  = 1'b1;
                end
            end
            S_CALC: begin
                if (cnt == LAST) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_DONE;
                load_out   = 1'b1;
            end
            S_DONE: begin
                if (Start) begin
                    state_next = S_CALC;
                    start_acc  = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next == S_CALC) || (state_next == S_FIX);
        done_next = (state_next == S_DONE);
    end

    // Operand magnitudes, one restoring step, and the final sign fix-up
    always_comb begin
        a_mag    = (Signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag    = (Signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted + ~{1'b0, bmag} + WX'(1);
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
        q_fix    = (sgn && (a_neg != b_neg)) ? (~quo + WIDTH'(1)) : quo;
        r_fix    = (sgn && a_neg) ? (~rem + WIDTH'(1)) : rem;
        if (bzero) begin
            q_fix = '1;
            r_fix = a_orig;
        end
    end

    // Datapath registers; outputs only move on the FIX->DONE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            bmag      <= '0;
            a_orig    <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            sgn       <= 1'b0;
            bzero     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            if (start_acc) begin
                sgn    <= Signed;
                a_neg  <= Signed & A[WIDTH-1];
                b_neg  <= Signed & B[WIDTH-1];
                bzero  <= (B == '0);
                a_orig <= A;
                quo    <= a_mag;
                bmag   <= b_mag;
                rem    <= '0;
                cnt    <= '0;
            end else if (state == S_CALC) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + CW'(1);
            end
            if (load_out) begin
                Quotient  <= q_fix;
                Remainder <= r_fix;
                DivByZero <= bzero;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: driver pushes expected results, a
// negedge monitor pops and compares on every Done pulse.
module tb_seq_divider32;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Start = 1'b0;
    logic         Signed = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivByZero;

    seq_divider32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Signed    (Signed),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic [31:0]  at;
    } exp_t;

    exp_t sbq[$];

    // Directed cases with hand-derived answers
    logic [W-1:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                             32'd12345, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] tb [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd2,
                             32'd0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic         ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] tq [8] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFC,
                             32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd0};
    logic [W-1:0] tr [8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd1,
                             32'd12345, 32'd0, 32'd0, 32'h8000_0000};
    logic         tz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating division, remainder follows dividend sign
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint dv;
        e = '0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            dv  = longint'($signed(b));
            e.q = W'(sa / dv);
            e.r = W'(sa % dv);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: scoreboard pop on Done, hold check otherwise
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_q = '0;
            last_r = '0;
            last_z = 1'b0;
        end else if (Done) begin
            chk("busy_with_done", W'(Busy), W'(0));
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=Done required=no Done at cycle %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("quotient", Quotient, mon_e.q);
                chk("remainder", Remainder, mon_e.r);
                chk("divbyzero", W'(DivByZero), W'(mon_e.dbz));
                chk("done_cycle", W'(cyc), mon_e.at);
            end
            last_q = Quotient;
            last_r = Remainder;
            last_z = DivByZero;
        end else begin
            chk("hold_quotient", Quotient, last_q);
            chk("hold_remainder", Remainder, last_r);
            chk("hold_divbyzero", W'(DivByZero), W'(last_z));
        end
    end

    // Drive one accepted Start; returns the cycle number of the Start edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int unsigned at);
        A      = a;
        B      = b;
        Signed = s;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        at     = cyc;
        Start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        Signed = 1'($urandom_range(0, 1));
        chk("busy_after_start", W'(Busy), W'(1));
    endtask

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                            input int unsigned at);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = z;
        e.at  = at + LAT;
        sbq.push_back(e);
    endtask

    task automatic wait_done(output int unsigned at);
        bit got;
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < int'(LAT) + 10; i++) begin
            @(negedge clk);
            if (Done) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout actual=no Done required=Done within %0d cycles", LAT + 10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        int unsigned d1;
        int unsigned d2;
        exp_t        e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        // Reset values
        #12;
        chk("reset_busy", W'(Busy), W'(0));
        chk("reset_done", W'(Done), W'(0));
        chk("reset_quotient", Quotient, '0);
        chk("reset_remainder", Remainder, '0);
        chk("reset_divbyzero", W'(DivByZero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, each from IDLE
        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb[i], ts[i], t0);
            push_exp(tq[i], tr[i], tz[i], t0);
            wait_done(d1);
            @(negedge clk);
        end

        // Start while busy is ignored, then a back-to-back op from DONE
        issue(32'd1000, 32'd10, 1'b0, t0);
        push_exp(32'd100, 32'd0, 1'b0, t0);
        repeat (4) @(posedge clk);
        #1;
        A      = 32'd5;
        B      = 32'd1;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        wait_done(d1);
        issue(32'd55, 32'd5, 1'b0, t0);
        push_exp(32'd11, 32'd0, 1'b0, t0);
        wait_done(d2);
        chk("done_spacing", W'(d2 - d1), W'(LAT + 1));
        @(negedge clk);

        // Reset in the middle of an operation
        issue(32'd100, 32'd7, 1'b0, t0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_quotient", Quotient, '0);
        chk("abort_remainder", Remainder, '0);
        chk("abort_busy", W'(Busy), W'(0));
        chk("abort_done", W'(Done), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        issue(32'd100, 32'd7, 1'b0, t0);
        push_exp(32'd14, 32'd2, 1'b0, t0);
        wait_done(d1);
        @(negedge clk);

        // Randomised operands, mixed idle gaps and back-to-back starts
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = W'($urandom_range(1, 15));
                3: begin
                    ra = 32'h8000_0000;
                    rb = $urandom;
                end
                default: rb = $urandom;
            endcase
            issue(ra, rb, rs, t0);
            e = model(ra, rb, rs);
            push_exp(e.q, e.r, e.dbz, t0);
            wait_done(d1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", W'(sbq.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
